// File: rtl/sn65lv1224_prbs_checker_pkg.sv
// Shared link definitions for the SN65LV1224 PRBS-7 checker: word geometry,
// FSM state encodings and the PRBS-7 (x^7+x^6+1) feedback tap.
package sn65lv1224_prbs_checker_pkg;

  localparam int WORD_W = 10;
  localparam int PRBS_W = 7;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b00,
    ST_SETTLE   = 2'b01,
    ST_SEED     = 2'b10,
    ST_CHECK    = 2'b11
  } link_state_e;

  function automatic logic prbs7_feedback(input logic [PRBS_W-1:0] s);
    return s[6] ^ s[5];
  endfunction

endpackage

// File: rtl/sn65lv1224_prbs_checker_prbs7_word10.sv
// Combinational PRBS-7 word engine: advances the generator 10 bits and
// returns those bits as a word with the first generated bit in [9].
module prbs7_word10
  import sn65lv1224_prbs_checker_pkg::*;
(
  input  logic [PRBS_W-1:0] state_in,
  output logic [WORD_W-1:0] word_out,
  output logic [PRBS_W-1:0] state_out
);

  logic [PRBS_W-1:0] lfsr_s;
  logic [WORD_W-1:0] word_s;
  logic              fb_s;

  // Unrolled 10-step advance; each new bit shifts in at the word LSB
  always_comb begin
    lfsr_s = state_in;
    word_s = {WORD_W{1'b0}};
    fb_s   = 1'b0;
    for (int i = 0; i < WORD_W; i++) begin
      fb_s   = prbs7_feedback(lfsr_s);
      word_s = {word_s[WORD_W-2:0], fb_s};
      lfsr_s = {lfsr_s[PRBS_W-2:0], fb_s};
    end
    word_out  = word_s;
    state_out = lfsr_s;
  end

endmodule

// File: rtl/sn65lv1224_prbs_checker.sv
// SN65LV1224 receive-side PRBS-7 checker: synchronises LOCK, self-seeds a
// word-wide predictor from the stream and counts good/bad words.
module sn65lv1224_prbs_checker
  import sn65lv1224_prbs_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1024,
  parameter int RESYNC_ERRORS = 4,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WORD_W-1:0]        rout,
  input  logic                     lock_n,
  input  logic                     clear_counters,
  output logic                     aligned,
  output logic                     error,
  output logic [COUNTER_WIDTH-1:0] word_count,
  output logic [COUNTER_WIDTH-1:0] error_count,
  output logic [1:0]               state_out
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int EW = $clog2(RESYNC_ERRORS + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [EW-1:0] RESYNC_LAST = EW'(RESYNC_ERRORS);
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};

  logic                     lock_meta_q, lock_meta_d;
  logic                     lock_sync_q, lock_sync_d;
  logic [WORD_W-1:0]        rx_q, rx_d;
  link_state_e              state_q, state_d;
  logic [SW-1:0]            settle_cnt_q, settle_cnt_d;
  logic [PRBS_W-1:0]        prbs_q, prbs_d;
  logic [EW-1:0]            consec_q, consec_d;
  logic [COUNTER_WIDTH-1:0] word_count_q, word_count_d;
  logic [COUNTER_WIDTH-1:0] error_count_q, error_count_d;
  logic                     error_q, error_d;
  logic                     aligned_q, aligned_d;

  logic [WORD_W-1:0]        expected_s;
  logic [PRBS_W-1:0]        prbs_next_s;
  logic [EW-1:0]            consec_plus_s;
  logic                     check_s;
  logic                     mismatch_s;

  prbs7_word10 u_prbs (
    .state_in  (prbs_q),
    .word_out  (expected_s),
    .state_out (prbs_next_s)
  );

  // LOCK is asynchronous to RCLK: two-flop synchroniser, inverted to active-high
  always_comb begin
    lock_meta_d = ~lock_n;
    lock_sync_d = lock_meta_q;
    rx_d        = rout;
  end

  // Synchroniser and input word register
  always_ff @(posedge clock) begin
    if (reset) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      rx_q        <= {WORD_W{1'b0}};
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
      rx_q        <= rx_d;
    end
  end

  assign consec_plus_s = consec_q + EW'(1);

  // Next-state logic: link FSM, settle timer, predictor and error run length
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    prbs_d       = prbs_q;
    consec_d     = consec_q;
    case (state_q)
      ST_UNLOCKED: begin
        settle_cnt_d = {SW{1'b0}};
        if (lock_sync_q) state_d = ST_SETTLE;
        else             state_d = ST_UNLOCKED;
      end
      ST_SETTLE: begin
        if (!lock_sync_q) begin
          state_d = ST_UNLOCKED;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d      = ST_SEED;
          settle_cnt_d = {SW{1'b0}};
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      ST_SEED: begin
        if (!lock_sync_q) begin
          state_d = ST_UNLOCKED;
        end else begin
          prbs_d   = rx_q[PRBS_W-1:0];
          consec_d = {EW{1'b0}};
          // An all-zero seed would lock the generator at zero forever
          if (rx_q[PRBS_W-1:0] == {PRBS_W{1'b0}}) state_d = ST_SEED;
          else                                    state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!lock_sync_q) begin
          state_d = ST_UNLOCKED;
        end else begin
          prbs_d = prbs_next_s;
          if (rx_q == expected_s) begin
            consec_d = {EW{1'b0}};
            state_d  = ST_CHECK;
          end else begin
            consec_d = consec_plus_s;
            if (consec_plus_s == RESYNC_LAST) state_d = ST_SEED;
            else                              state_d = ST_CHECK;
          end
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_UNLOCKED;
      settle_cnt_q <= {SW{1'b0}};
      prbs_q       <= {PRBS_W{1'b0}};
      consec_q     <= {EW{1'b0}};
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      prbs_q       <= prbs_d;
      consec_q     <= consec_d;
    end
  end

  // Output logic: a word is only scored while locked in CHECK
  always_comb begin
    check_s    = (state_q == ST_CHECK) && lock_sync_q;
    mismatch_s = check_s && (rx_q != expected_s);
    if (clear_counters)                         word_count_d = {COUNTER_WIDTH{1'b0}};
    else if (check_s && (word_count_q != CNT_MAX)) word_count_d = word_count_q + CNT_ONE;
    else                                        word_count_d = word_count_q;
    if (clear_counters)                            error_count_d = {COUNTER_WIDTH{1'b0}};
    else if (mismatch_s && (error_count_q != CNT_MAX)) error_count_d = error_count_q + CNT_ONE;
    else                                           error_count_d = error_count_q;
    error_d   = mismatch_s;
    aligned_d = (state_d == ST_CHECK);
  end

  // Registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      word_count_q  <= {COUNTER_WIDTH{1'b0}};
      error_count_q <= {COUNTER_WIDTH{1'b0}};
      error_q       <= 1'b0;
      aligned_q     <= 1'b0;
    end else begin
      word_count_q  <= word_count_d;
      error_count_q <= error_count_d;
      error_q       <= error_d;
      aligned_q     <= aligned_d;
    end
  end

  assign aligned     = aligned_q;
  assign error       = error_q;
  assign word_count  = word_count_q;
  assign error_count = error_count_q;
  assign state_out   = state_q;

endmodule
